// File: rtl/tdc_enc_pkg.sv
// Shared types and helpers for the multi-channel ring-oscillator TDC encoder.
// Result fields are sized for the largest legal configuration (NCH<=16, NTAP<=127, CW<=32).
package tdc_enc_pkg;

    localparam int MAX_CHW = 4;
    localparam int MAX_CW  = 32;
    localparam int MAX_FW  = 8;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } scan_state_e;

    typedef struct packed {
        logic [MAX_CHW-1:0] chan;
        logic [MAX_CW-1:0]  coarse;
        logic [MAX_FW-1:0]  fine;
        logic               err;
    } tdc_result_t;

    function automatic int fine_w(input int ntap);
        return $clog2(2 * ntap);
    endfunction

    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic logic [7:0] popcount(input logic [127:0] v);
        logic [7:0] n;
        n = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tdc_ring_decode.sv
// Combinational ring decode: equal-neighbour pair vector ahead of stage 1,
// first-pair priority and pair count behind it.
module tdc_ring_decode
    import tdc_enc_pkg::*;
#(
    parameter int NTAP = 63,
    parameter int FW   = fine_w(NTAP)
) (
    input  logic [NTAP-1:0] snap,
    output logic [NTAP-1:0] e_pair,
    input  logic [NTAP-1:0] s_q,
    input  logic [NTAP-1:0] e_q,
    output logic [FW-1:0]   fine,
    output logic            err
);

    logic [7:0]    npair;
    logic [FW-1:0] pos;
    logic          s_at_pos;
    logic          found;

    // Bit k compares S[k] with S[k-1], wrapping tap 0 onto the last tap.
    assign e_pair = ~(snap ^ {snap[NTAP-2:0], snap[NTAP-1]});

    always_comb begin
        pos      = '0;
        s_at_pos = 1'b0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NTAP; k++) begin
            if (e_q[k] && !found) begin
                pos      = FW'(k);
                s_at_pos = s_q[k];
                found    = 1'b1;
            end
        end
        npair = popcount(128'(e_q));
        fine  = s_at_pos ? pos + FW'(NTAP) : pos;
        err   = (npair != 8'd1);
    end

endmodule

// File: rtl/tdc_ring_encoder.sv
// Multi-channel TDC capture: per-channel holding registers, round-robin scanner,
// shared two-stage ring encoder and a shift-register output FIFO.
module tdc_ring_encoder
    import tdc_enc_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int NTAP  = 63,
    parameter  int CW    = 8,
    parameter  int DEPTH = 4,
    localparam int FW    = fine_w(NTAP),
    localparam int CHW   = chan_w(NCH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH-1:0]       hit_valid,
    input  logic [NCH*NTAP-1:0]  raw_snap,
    input  logic [NCH*CW-1:0]    raw_coarse,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_chan,
    output logic [CW-1:0]        out_coarse,
    output logic [FW-1:0]        out_fine,
    output logic                 out_err,
    output logic [NCH-1:0]       ovf_sticky,
    input  logic [NCH-1:0]       ovf_clr
);

    localparam int CNTW = $clog2(DEPTH + 1);

    scan_state_e      state_q, state_d;
    logic [NCH-1:0]   pending_q;
    logic [NCH-1:0]   gnt_vec;
    logic [NTAP-1:0]  hold_snap_q   [NCH];
    logic [CW-1:0]    hold_coarse_q [NCH];
    logic [CHW-1:0]   rr_ptr_q;
    logic [CHW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             room;
    logic             grant;

    logic [NTAP-1:0]  sel_snap;
    logic [NTAP-1:0]  e_pair;
    logic             s1_v_q;
    logic [NTAP-1:0]  s1_e_q;
    logic [NTAP-1:0]  s1_s_q;
    logic [CHW-1:0]   s1_chan_q;
    logic [CW-1:0]    s1_coarse_q;
    logic [FW-1:0]    s2_fine;
    logic             s2_err;

    tdc_result_t      fifo_q [DEPTH];
    tdc_result_t      wdata;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  wr_idx;
    logic             push;
    logic             pop;

    // A grant adds one result in flight; gating on occupancy + stage-1 valid keeps the FIFO from overrunning.
    assign room = (int'(count_q) + int'(s1_v_q)) < DEPTH;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!gnt_found && pending_q[c] && (c >= 32'(rr_ptr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = CHW'(c);
            end
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!gnt_found && pending_q[c]) begin
                gnt_found = 1'b1;
                gnt_idx   = CHW'(c);
            end
        end
    end

    assign grant   = (state_q == ST_GRANT) && gnt_found && room;
    assign gnt_vec = grant ? (NCH'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gnt_found && room) state_d = ST_GRANT;
            ST_GRANT: if (!(gnt_found && room)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rr_ptr_q <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CHW'(1);
            end
        end
    end

    // A channel granted this cycle frees its holding register for a same-cycle hit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q  <= '0;
            ovf_sticky <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                hold_snap_q[c]   <= '0;
                hold_coarse_q[c] <= '0;
            end
        end else begin
            pending_q  <= (pending_q & ~gnt_vec) | hit_valid;
            ovf_sticky <= (ovf_sticky & ~ovf_clr) | (hit_valid & pending_q & ~gnt_vec);
            for (int unsigned c = 0; c < NCH; c++) begin
                if (hit_valid[c] && (!pending_q[c] || gnt_vec[c])) begin
                    hold_snap_q[c]   <= raw_snap[c*NTAP +: NTAP];
                    hold_coarse_q[c] <= raw_coarse[c*CW +: CW];
                end
            end
        end
    end

    assign sel_snap = hold_snap_q[gnt_idx];

    tdc_ring_decode #(
        .NTAP (NTAP),
        .FW   (FW)
    ) u_decode (
        .snap   (sel_snap),
        .e_pair (e_pair),
        .s_q    (s1_s_q),
        .e_q    (s1_e_q),
        .fine   (s2_fine),
        .err    (s2_err)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v_q      <= 1'b0;
            s1_e_q      <= '0;
            s1_s_q      <= '0;
            s1_chan_q   <= '0;
            s1_coarse_q <= '0;
        end else begin
            s1_v_q <= grant;
            if (grant) begin
                s1_e_q      <= e_pair;
                s1_s_q      <= sel_snap;
                s1_chan_q   <= gnt_idx;
                s1_coarse_q <= hold_coarse_q[gnt_idx];
            end
        end
    end

    always_comb begin
        wdata        = '0;
        wdata.chan   = MAX_CHW'(s1_chan_q);
        wdata.coarse = MAX_CW'(s1_coarse_q);
        wdata.fine   = MAX_FW'(s2_fine);
        wdata.err    = s2_err;
    end

    assign push   = s1_v_q;
    assign pop    = out_valid && out_ready;
    assign wr_idx = pop ? count_q - CNTW'(1) : count_q;

    // Entry 0 is the head; a pop shifts everything down one slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    fifo_q[i] <= fifo_q[i+1];
                end
            end
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CNTW'(i) == wr_idx) fifo_q[i] <= wdata;
                end
            end
            count_q <= count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (count_q == CNTW'(DEPTH))));

    assign out_valid  = (count_q != '0);
    assign out_chan   = CHW'(fifo_q[0].chan);
    assign out_coarse = CW'(fifo_q[0].coarse);
    assign out_fine   = FW'(fifo_q[0].fine);
    assign out_err    = fifo_q[0].err;

endmodule

// File: tb/tb_tdc_ring_encoder.sv
// Directed bench for tdc_ring_encoder: encoding cases, round robin, back-pressure,
// overflow flags and asynchronous reset.
module tb_tdc_ring_encoder;

    localparam int NCH   = 4;
    localparam int NTAP  = 63;
    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int FW    = 7;
    localparam int CHW   = 2;

    logic                clk;
    logic                rstn;
    logic [NCH-1:0]      hit_valid;
    logic [NCH*NTAP-1:0] raw_snap;
    logic [NCH*CW-1:0]   raw_coarse;
    logic                out_valid;
    logic                out_ready;
    logic [CHW-1:0]      out_chan;
    logic [CW-1:0]       out_coarse;
    logic [FW-1:0]       out_fine;
    logic                out_err;
    logic [NCH-1:0]      ovf_sticky;
    logic [NCH-1:0]      ovf_clr;

    int checks;
    int errors;

    logic [NTAP-1:0] v_alt, v_inv, v_one, v_three;

    tdc_ring_encoder #(
        .NCH   (NCH),
        .NTAP  (NTAP),
        .CW    (CW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hit_valid  (hit_valid),
        .raw_snap   (raw_snap),
        .raw_coarse (raw_coarse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_coarse (out_coarse),
        .out_fine   (out_fine),
        .out_err    (out_err),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Alternating taps whose phase flips at each listed index (-1 = unused).
    function automatic logic [NTAP-1:0] ring_vec(input int b0, input int b1, input int b2);
        logic [NTAP-1:0] v;
        int ph;
        ph = 0;
        for (int k = 0; k < NTAP; k++) begin
            if (k == b0 || k == b1 || k == b2) ph = ph ^ 1;
            v[k] = (((k + ph) % 2) == 1);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int ch, input int co, input int fi, input int er);
        chk({tag, ".valid"},  64'(out_valid),  64'd1);
        chk({tag, ".chan"},   64'(out_chan),   64'(ch));
        chk({tag, ".coarse"}, 64'(out_coarse), 64'(co));
        chk({tag, ".fine"},   64'(out_fine),   64'(fi));
        chk({tag, ".err"},    64'(out_err),    64'(er));
    endtask

    task automatic set_hit(input int ch, input logic [NTAP-1:0] s, input int co);
        hit_valid[ch]             = 1'b1;
        raw_snap[ch*NTAP +: NTAP] = s;
        raw_coarse[ch*CW +: CW]   = CW'(co);
    endtask

    task automatic step();
        @(negedge clk);
        hit_valid = '0;
        ovf_clr   = '0;
    endtask

    task automatic single(input string tag, input int ch, input logic [NTAP-1:0] s,
                          input int co, input int fi, input int er);
        set_hit(ch, s, co);
        step();
        step();
        step();
        chk({tag, ".lat3"}, 64'(out_valid), 64'd0);
        step();
        expect_out(tag, ch, co, fi, er);
        step();
        chk({tag, ".drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rstn       = 1'b0;
        hit_valid  = '0;
        raw_snap   = '0;
        raw_coarse = '0;
        out_ready  = 1'b1;
        ovf_clr    = '0;
        v_alt      = ring_vec(-1, -1, -1);
        v_inv      = ring_vec(0, -1, -1);
        v_one      = ring_vec(10, -1, -1);
        v_three    = ring_vec(9, 20, 30);

        repeat (3) @(negedge clk);
        chk("rst.valid",  64'(out_valid),  64'd0);
        chk("rst.chan",   64'(out_chan),   64'd0);
        chk("rst.coarse", 64'(out_coarse), 64'd0);
        chk("rst.fine",   64'(out_fine),   64'd0);
        chk("rst.err",    64'(out_err),    64'd0);
        chk("rst.ovf",    64'(ovf_sticky), 64'd0);
        rstn = 1'b1;
        step();
        chk("rst.idle", 64'(out_valid), 64'd0);

        single("t1",  2, v_alt,   'h5A, 0,  0);
        single("t2a", 0, v_inv,   'h01, 63, 0);
        single("t2b", 0, v_one,   'h02, 73, 0);
        single("t2c", 0, v_three, 'h03, 9,  1);
        single("t3a", 0, '1,      'hFF, 63, 1);
        single("t3b", 0, '0,      'h00, 0,  1);

        // rr_ptr is 1 after the ch0 grants above
        for (int c = 0; c < NCH; c++) set_hit(c, v_alt, 'h10 + c);
        step();
        step();
        step();
        chk("t4.lat3", 64'(out_valid), 64'd0);
        step();
        expect_out("t4.r0", 1, 'h11, 0, 0);
        step();
        expect_out("t4.r1", 2, 'h12, 0, 0);
        step();
        expect_out("t4.r2", 3, 'h13, 0, 0);
        step();
        expect_out("t4.r3", 0, 'h10, 0, 0);
        step();
        chk("t4.drained", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        for (int c = 0; c < NCH; c++) set_hit(c, v_inv, 'h20 + c);
        repeat (7) step();
        expect_out("t5.full", 1, 'h21, 63, 0);
        set_hit(1, v_alt, 'h31);
        set_hit(2, v_alt, 'h32);
        step();
        expect_out("t5.hold1", 1, 'h21, 63, 0);
        step();
        set_hit(1, v_three, 'h3F);
        step();
        chk("t5.ovf_set", 64'(ovf_sticky), 64'h2);
        expect_out("t5.hold2", 1, 'h21, 63, 0);
        out_ready = 1'b1;
        step();
        expect_out("t5.d1", 2, 'h22, 63, 0);
        step();
        expect_out("t5.d2", 3, 'h23, 63, 0);
        step();
        expect_out("t5.d3", 0, 'h20, 63, 0);
        step();
        expect_out("t5.d4", 1, 'h31, 0, 0);
        step();
        expect_out("t5.d5", 2, 'h32, 0, 0);
        step();
        chk("t5.drained", 64'(out_valid), 64'd0);
        ovf_clr = 4'b0010;
        step();
        chk("t5.ovf_clr", 64'(ovf_sticky), 64'h0);

        set_hit(3, v_alt, 'h55);
        step();
        set_hit(3, v_three, 'h66);
        ovf_clr = 4'b1000;
        step();
        chk("t7.set_wins", 64'(ovf_sticky), 64'h8);
        ovf_clr = 4'b1000;
        step();
        chk("t7.cleared", 64'(ovf_sticky), 64'h0);
        chk("t7.lat3", 64'(out_valid), 64'd0);
        step();
        expect_out("t7.res", 3, 'h55, 0, 0);
        step();
        chk("t7.drained", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        for (int c = 0; c < NCH; c++) set_hit(c, v_alt, 'h40 + c);
        step();
        set_hit(2, v_alt, 'h4F);
        step();
        step();
        step();
        chk("t6.pre_valid", 64'(out_valid), 64'd1);
        chk("t6.pre_ovf",   64'(ovf_sticky), 64'h4);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6.valid",  64'(out_valid),  64'd0);
        chk("t6.chan",   64'(out_chan),   64'd0);
        chk("t6.coarse", 64'(out_coarse), 64'd0);
        chk("t6.fine",   64'(out_fine),   64'd0);
        chk("t6.err",    64'(out_err),    64'd0);
        chk("t6.ovf",    64'(ovf_sticky), 64'd0);
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t6.no_stale", 64'(out_valid), 64'd0);
        single("t6.post", 1, v_one, 'h77, 73, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
